frame_write_burst_ctrl: RTL and testbench

- Per-channel write master sitting directly upstream of the multi-port memory controller. Drains a dual-clock pixel FIFO (read side on mem_clk) into one chN_wr_burst_* port.
- Issues fixed-size bursts into a frame buffer selected by a frame index.
- Frame start uses a four-phase req/ack handshake with the video-side frame control logic.

---
 rtl/frame_write_burst_ctrl_pkg.sv | 19 +
 rtl/frame_write_burst_ctrl.sv | 120 ++++++++++++
 tb/tb_frame_write_burst_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_write_burst_ctrl_pkg.sv
// Shared definitions for the per-channel frame write burst master:
// default geometry and the controller state encoding.
package frame_write_burst_ctrl_pkg;

  localparam int unsigned DEF_MEM_DATA_BITS = 64;
  localparam int unsigned DEF_ADDR_BITS     = 24;
  localparam int unsigned DEF_BURST_LEN     = 128;
  localparam int unsigned DEF_USEDW_BITS    = 10;
  localparam int unsigned DEF_FRAME_STRIDE  = 32'h0008_0000;
  localparam int unsigned BURST_LEN_BITS    = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    CHECK = 2'd2,
    BURST = 2'd3
  } wb_state_t;

endpackage

// File: rtl/frame_write_burst_ctrl.sv
// Write master: drains the show-ahead pixel FIFO into fixed-size bursts on one
// memory controller write port, one frame buffer per req/ack handshake.
module frame_write_burst_ctrl
  import frame_write_burst_ctrl_pkg::*;
#(
  parameter int unsigned MEM_DATA_BITS = DEF_MEM_DATA_BITS,
  parameter int unsigned ADDR_BITS     = DEF_ADDR_BITS,
  parameter int unsigned BURST_LEN     = DEF_BURST_LEN,
  parameter int unsigned USEDW_BITS    = DEF_USEDW_BITS,
  parameter int unsigned FRAME_STRIDE  = DEF_FRAME_STRIDE
) (
  input  logic                      mem_clk,
  input  logic                      rst_n,
  input  logic                      write_req,
  output logic                      write_req_ack,
  input  logic [1:0]                write_addr_index,
  input  logic [ADDR_BITS-1:0]      write_len,
  output logic                      write_done,
  output logic                      fifo_aclr,
  input  logic [USEDW_BITS-1:0]     fifo_rdusedw,
  output logic                      fifo_rdreq,
  output logic                      wr_burst_req,
  output logic [BURST_LEN_BITS-1:0] wr_burst_len,
  output logic [ADDR_BITS-1:0]      wr_burst_addr,
  input  logic                      wr_burst_data_req,
  input  logic                      wr_burst_finish
);

  localparam logic [ADDR_BITS-1:0] STRIDE    = ADDR_BITS'(FRAME_STRIDE);
  localparam logic [ADDR_BITS-1:0] BURST_MAX = ADDR_BITS'(BURST_LEN);

  if (BURST_LEN < 1 || BURST_LEN > 1023 || MEM_DATA_BITS == 0) begin : g_param_check
    $error("frame_write_burst_ctrl: BURST_LEN must be 1..1023");
  end

  wb_state_t state, state_nxt;

  logic [ADDR_BITS-1:0] base;
  logic [ADDR_BITS-1:0] len;
  logic [ADDR_BITS-1:0] written;
  logic [ADDR_BITS-1:0] remaining;
  logic [ADDR_BITS-1:0] blen;
  logic                 frame_complete;
  logic                 fill_ok;
  logic                 relatch;
  logic                 launch;

  assign remaining      = len - written;
  assign frame_complete = (remaining == '0);
  assign blen           = (remaining < BURST_MAX) ? remaining : BURST_MAX;
  assign fill_ok        = (ADDR_BITS'(fifo_rdusedw) >= blen);

  // A new request is latched both from IDLE and when abandoning a frame in CHECK.
  assign relatch = (state_nxt == ACK) && (state != ACK);
  assign launch  = (state == CHECK) && (state_nxt == BURST);

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A finished frame reports done before any pending request is taken from IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (write_req) state_nxt = ACK;
      ACK:   if (!write_req) state_nxt = CHECK;
      CHECK: begin
        if (frame_complete)  state_nxt = IDLE;
        else if (write_req)  state_nxt = ACK;
        else if (fill_ok)    state_nxt = BURST;
      end
      BURST: if (wr_burst_finish) state_nxt = CHECK;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    write_req_ack = 1'b0;
    fifo_aclr     = 1'b0;
    write_done    = 1'b0;
    wr_burst_req  = 1'b0;
    fifo_rdreq    = 1'b0;
    unique case (state)
      ACK: begin
        write_req_ack = 1'b1;
        fifo_aclr     = 1'b1;
      end
      CHECK: write_done = frame_complete;
      BURST: begin
        wr_burst_req = 1'b1;
        fifo_rdreq   = wr_burst_data_req;
      end
      default: ;
    endcase
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      base          <= '0;
      len           <= '0;
      written       <= '0;
      wr_burst_len  <= '0;
      wr_burst_addr <= '0;
    end else if (relatch) begin
      base    <= ADDR_BITS'(write_addr_index) * STRIDE;
      len     <= write_len;
      written <= '0;
    end else if (launch) begin
      wr_burst_len  <= blen[BURST_LEN_BITS-1:0];
      wr_burst_addr <= base + written;
    end else if (state == BURST && wr_burst_finish) begin
      written <= written + ADDR_BITS'(wr_burst_len);
    end
  end

endmodule

// File: tb/tb_frame_write_burst_ctrl.sv
// Directed plus randomized frames against a list-of-bursts reference model,
// with the bench acting as the memory controller write port.
module tb_frame_write_burst_ctrl;

  logic        mem_clk;
  logic        rst_n;
  logic        write_req;
  logic        write_req_ack;
  logic [1:0]  write_addr_index;
  logic [23:0] write_len;
  logic        write_done;
  logic        fifo_aclr;
  logic [9:0]  fifo_rdusedw;
  logic        fifo_rdreq;
  logic        wr_burst_req;
  logic [9:0]  wr_burst_len;
  logic [23:0] wr_burst_addr;
  logic        wr_burst_data_req;
  logic        wr_burst_finish;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [23:0] addr;
    int unsigned len;
  } burst_t;

  burst_t exp_q[$];

  frame_write_burst_ctrl #(
    .MEM_DATA_BITS(64),
    .ADDR_BITS    (24),
    .BURST_LEN    (128),
    .USEDW_BITS   (10),
    .FRAME_STRIDE (32'h0008_0000)
  ) dut (
    .mem_clk          (mem_clk),
    .rst_n            (rst_n),
    .write_req        (write_req),
    .write_req_ack    (write_req_ack),
    .write_addr_index (write_addr_index),
    .write_len        (write_len),
    .write_done       (write_done),
    .fifo_aclr        (fifo_aclr),
    .fifo_rdusedw     (fifo_rdusedw),
    .fifo_rdreq       (fifo_rdreq),
    .wr_burst_req     (wr_burst_req),
    .wr_burst_len     (wr_burst_len),
    .wr_burst_addr    (wr_burst_addr),
    .wr_burst_data_req(wr_burst_data_req),
    .wr_burst_finish  (wr_burst_finish)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: a frame is cut into BURST_LEN-word pieces, the last one short.
  task automatic model_frame(input int unsigned idx, input int unsigned flen);
    longint unsigned base;
    int unsigned off;
    int unsigned b;
    base = longint'(idx) * 64'h80000;
    off  = 0;
    exp_q.delete();
    while (off < flen) begin
      b = (flen - off > 128) ? 128 : flen - off;
      exp_q.push_back('{addr: 24'((base + off) % 64'h100_0000), len: b});
      off += b;
    end
  endtask

  task automatic handshake(input logic [1:0] idx, input logic [23:0] flen);
    int n;
    write_addr_index = idx;
    write_len        = flen;
    write_req        = 1'b1;
    n = 0;
    do begin
      @(negedge mem_clk);
      n++;
    end while (!write_req_ack && n < 10);
    chk("ack_high", write_req_ack, 1);
    chk("aclr_high", fifo_aclr, 1);
    @(negedge mem_clk);
    chk("ack_held", write_req_ack, 1);
    write_req = 1'b0;
    @(negedge mem_clk);
    chk("ack_low", write_req_ack, 0);
    chk("aclr_low", fifo_aclr, 0);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!wr_burst_req && n < 20) begin
      @(negedge mem_clk);
      n++;
    end
    chk("req_wait", wr_burst_req, 1);
  endtask

  task automatic serve_burst(input logic [23:0] ea, input int unsigned el, input int raise_at,
                             input logic [1:0] new_idx, input logic [23:0] new_len,
                             output int unsigned words);
    bit stable;
    stable = 1'b1;
    words  = 0;
    chk("burst_addr", wr_burst_addr, ea);
    chk("burst_len", wr_burst_len, el);
    for (int i = 0; i < int'(el); i++) begin
      wr_burst_data_req = 1'b1;
      if (i == raise_at) begin
        write_req        = 1'b1;
        write_addr_index = new_idx;
        write_len        = new_len;
      end
      #1;
      if (fifo_rdreq) words++;
      if (!wr_burst_req || wr_burst_addr !== ea || wr_burst_len !== 10'(el)) stable = 1'b0;
      @(negedge mem_clk);
    end
    wr_burst_data_req = 1'b0;
    wr_burst_finish   = 1'b1;
    #1;
    if (!wr_burst_req) stable = 1'b0;
    @(negedge mem_clk);
    wr_burst_finish = 1'b0;
    chk("burst_stable", stable, 1);
    chk("req_drop", wr_burst_req, 0);
    chk("burst_rdreqs", words, el);
  endtask

  task automatic drain(input int unsigned idx, input int unsigned flen);
    int unsigned total_words;
    int unsigned w;
    int          idle;
    bit          done_seen;
    bit          abort;
    burst_t      e;
    model_frame(idx, flen);
    total_words = 0;
    idle        = 0;
    done_seen   = 1'b0;
    abort       = 1'b0;
    while (!done_seen && !abort && idle < 20) begin
      if (write_done) begin
        done_seen = 1'b1;
      end else if (wr_burst_req) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_burst", wr_burst_req, 0);
          abort = 1'b1;
        end else begin
          e = exp_q.pop_front();
          serve_burst(e.addr, e.len, -1, 2'd0, 24'd0, w);
          total_words += w;
          idle = 0;
          if (exp_q.size() != 0) begin
            @(negedge mem_clk);
            chk("next_req_2cyc", wr_burst_req, 1);
          end
        end
      end else begin
        @(negedge mem_clk);
        idle++;
      end
    end
    chk("done_seen", done_seen, 1);
    chk("bursts_left", exp_q.size(), 0);
    chk("rdreq_total", total_words, flen);
    @(negedge mem_clk);
    chk("done_one_cycle", write_done, 0);
  endtask

  task automatic wait_done();
    int n;
    bit stray;
    n     = 0;
    stray = 1'b0;
    while (!write_done && n < 20) begin
      @(negedge mem_clk);
      n++;
      if (wr_burst_req) stray = 1'b1;
    end
    chk("done_pulse", write_done, 1);
    chk("no_stray_burst", stray, 0);
    @(negedge mem_clk);
    chk("done_low", write_done, 0);
  endtask

  initial begin
    int unsigned w;
    bit seen;
    int unsigned ridx;
    int unsigned rlen;

    rst_n             = 1'b0;
    write_req         = 1'b0;
    write_addr_index  = 2'd0;
    write_len         = 24'd0;
    fifo_rdusedw      = 10'd0;
    wr_burst_data_req = 1'b0;
    wr_burst_finish   = 1'b0;
    repeat (3) @(negedge mem_clk);
    chk("reset_outputs", {write_req_ack, write_done, fifo_aclr, fifo_rdreq,
                          wr_burst_req, wr_burst_len, wr_burst_addr}, 64'd0);
    rst_n = 1'b1;
    @(negedge mem_clk);

    // Data requests outside a burst must not strobe the FIFO.
    wr_burst_data_req = 1'b1;
    #1 chk("ungated_idle", fifo_rdreq, 0);
    wr_burst_data_req = 1'b0;

    // Frame 1, two full bursts.
    fifo_rdusedw = 10'd300;
    handshake(2'd1, 24'd256);
    drain(1, 256);

    // Short tail burst that must wait for FIFO fill.
    fifo_rdusedw = 10'd300;
    handshake(2'd0, 24'd200);
    wait_req();
    serve_burst(24'h000000, 128, -1, 2'd0, 24'd0, w);
    fifo_rdusedw = 10'd50;
    wr_burst_data_req = 1'b1;
    #1 chk("ungated_check", fifo_rdreq, 0);
    wr_burst_data_req = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge mem_clk);
      if (wr_burst_req) seen = 1'b1;
    end
    chk("tail_wait_50", seen, 0);
    fifo_rdusedw = 10'd71;
    @(negedge mem_clk);
    chk("tail_wait_71", wr_burst_req, 0);
    fifo_rdusedw = 10'd72;
    @(negedge mem_clk);
    chk("tail_go_72", wr_burst_req, 1);
    serve_burst(24'h000080, 72, -1, 2'd0, 24'd0, w);
    wait_done();

    // Starvation one word short of a full burst.
    fifo_rdusedw = 10'd127;
    handshake(2'd3, 24'd128);
    seen = 1'b0;
    repeat (8) begin
      @(negedge mem_clk);
      if (wr_burst_req) seen = 1'b1;
    end
    chk("starve_no_req", seen, 0);
    fifo_rdusedw = 10'd128;
    @(negedge mem_clk);
    chk("starve_req_1cyc", wr_burst_req, 1);
    serve_burst(24'h180000, 128, -1, 2'd0, 24'd0, w);
    wait_done();

    // New request mid-burst: burst completes, then frame 2 restarts.
    fifo_rdusedw = 10'd1023;
    handshake(2'd0, 24'd512);
    wait_req();
    serve_burst(24'h000000, 128, 40, 2'd2, 24'd256, w);
    chk("rereq_no_done", write_done, 0);
    chk("rereq_no_req", wr_burst_req, 0);
    @(negedge mem_clk);
    chk("rereq_ack", write_req_ack, 1);
    write_req = 1'b0;
    @(negedge mem_clk);
    chk("rereq_ack_low", write_req_ack, 0);
    drain(2, 256);

    // Asynchronous reset in the middle of a burst.
    handshake(2'd1, 24'd256);
    wait_req();
    repeat (50) begin
      wr_burst_data_req = 1'b1;
      @(negedge mem_clk);
    end
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_burst", {write_req_ack, write_done, fifo_aclr, fifo_rdreq,
                               wr_burst_req, wr_burst_len, wr_burst_addr}, 64'd0);
    wr_burst_data_req = 1'b0;
    @(negedge mem_clk);
    rst_n = 1'b1;
    @(negedge mem_clk);
    chk("post_reset_idle", {write_req_ack, wr_burst_req}, 64'd0);
    handshake(2'd2, 24'd130);
    drain(2, 130);

    // Zero-length frame.
    handshake(2'd1, 24'd0);
    drain(1, 0);

    // Randomized frames with the FIFO always able to cover a full burst.
    for (int k = 0; k < 4; k++) begin
      ridx         = $urandom_range(0, 3);
      rlen         = $urandom_range(1, 700);
      fifo_rdusedw = 10'($urandom_range(128, 1023));
      handshake(2'(ridx), 24'(rlen));
      drain(ridx, rlen);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
